multi_cycle_controller: RTL and testbench
=========================================

Name: multi_cycle_controller

Overview:
- Moore FSM that sequences the multi-cycle MIPS-subset datapath: shared instruction/data memory, IR, A/B/ALUOut/MDR registers, one ALU.
- Supported: R-type, ADDI, ADDIU, BEQ, J, LW, SW, LUI, ORI.
- Decodes opcode once per instruction and steps the datapath through fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, state register width; exported on state_o for debug.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from IR; sampled in DECODE only
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if zero=1
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- RegDst  out  1  write register select: 1 = rd, 0 = rt
- MemtoReg  out  1  write data select: 1 = MDR, 0 = ALUOut
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
- ALUOp  out  3  000 add, 001 sub, 010 funct, 011 lui, 100 or
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- Ext_op  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- instr_count  out  32  retired instructions (see Optional Feature)
- state_o  out  STATE_W  current state

Behaviour:
- Clock/reset: one clock clk. Reset rst_n is asynchronous, active-low.
- Reset:
  - state = IDLE; instr_count = 0.
  - All control outputs 0; ALUOp, ALUSrcB and PCSource = 0.
- Output timing: all outputs are pure decode of the state register (Moore); no output depends combinationally on opcode or zero. Outputs not listed for a state are 0.
- State encoding, transitions and asserted outputs:
  - IDLE (0): -> FETCH unconditionally. Gives one quiet cycle after reset.
  - FETCH (1): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
    - IRWrite and PCWrite are asserted only while mem_ready=1.
    - Stays in FETCH while mem_ready=0; -> DECODE when mem_ready=1.
  - DECODE (2): ALUSrcA=0, ALUSrcB=11, ALUOp=000, Ext_op=1 (branch target into ALUOut). Next state by opcode:
    - 000000 -> EXEC_R
    - LW (100011), SW (101011) -> MEM_ADDR
    - BEQ (000100) -> BRANCH
    - J (000010) -> JUMP
    - ADDI (001000), ADDIU (001001), LUI (001111), ORI (001101) -> EXEC_I
    - any other opcode -> FETCH, with illegal_op=1 for that one DECODE cycle. illegal_op is the single exception to pure state decode: DECODE state gated by the opcode-is-illegal check.
  - EXEC_R (3): ALUSrcA=1, ALUSrcB=00, ALUOp=010; -> WB_R.
  - WB_R (4): RegWrite, RegDst=1, MemtoReg=0; -> FETCH.
  - MEM_ADDR (5): ALUSrcA=1, ALUSrcB=10, ALUOp=000, Ext_op=1. -> MEM_RD if the latched opcode is LW, else -> MEM_WR.
  - MEM_RD (6): MemRead, IorD=1. Waits for mem_ready; -> WB_MEM when mem_ready=1.
  - WB_MEM (7): RegWrite, RegDst=0, MemtoReg=1; -> FETCH.
  - MEM_WR (8): MemWrite, IorD=1. Waits for mem_ready; -> FETCH when mem_ready=1.
  - BRANCH (9): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01; -> FETCH.
  - JUMP (10): PCWrite, PCSource=10; -> FETCH.
  - EXEC_I (11): ALUSrcA=1, ALUSrcB=10. ALUOp and Ext_op by latched opcode:
    - ADDI: 000, Ext_op=1
    - ADDIU: 000, Ext_op=1
    - LUI: 011, Ext_op=0
    - ORI: 100, Ext_op=0
    - -> WB_I.
  - WB_I (12): RegWrite, RegDst=0, MemtoReg=0; -> FETCH.
  - States 13-15: unreachable; -> IDLE.
- Opcode latching: opcode is latched into an internal register in DECODE. Later states use only the latched copy, so an IR change after DECODE has no effect.
- Cycle counts with mem_ready held 1:
  - BEQ, J: 3 cycles
  - R-type, I-type ALU, SW: 4 cycles
  - LW: 5 cycles
- Memory stalls: each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Request outputs stay asserted and stable throughout the stall.
- Reset mid-instruction: state returns to IDLE immediately (asynchronously). No partial write completes after rst_n falls.
- Retirement: an instruction retires on exit from WB_R, WB_MEM, WB_I, BRANCH, JUMP, and on MEM_WR exit with mem_ready=1. An illegal opcode does not retire.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined: instr_count is a 32-bit register, reset to 0, incremented by 1 on each retirement. Wraps from 0xFFFFFFFF to 0 silently.
- Undefined: no counter is built; instr_count is tied to 32'h0.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-EXEC_R -> state_o=0 and all outputs 0 immediately.
  - Release rst_n -> IDLE for 1 cycle, then FETCH.
- R-type:
  - opcode=000000, mem_ready=1 -> states 1,2,3,4,1.
  - RegWrite=1 with RegDst=1 only in WB_R; ALUOp=010 in EXEC_R.
- LW with stalls:
  - opcode=100011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD -> 10 cycles total.
  - IRWrite pulses exactly once.
  - MemRead held through every stall cycle.
- BEQ and J:
  - BEQ (000100), zero=1 -> BRANCH asserts PCWriteCond, PCSource=01, ALUOp=001; total 3 cycles.
  - J (000010) -> JUMP asserts PCWrite, PCSource=10.
- Illegal opcode and immediate forms:
  - opcode=111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH; instr_count unchanged.
  - ORI -> ALUOp=100, Ext_op=0.
  - LUI -> ALUOp=011.
- Counter (INSTR_COUNT_EN defined):
  - Run SW, ADDI, J -> instr_count=3.
  - Preload/force counter to 0xFFFFFFFF, retire one instruction -> instr_count=0.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: Moore control FSM for a multi-cycle MIPS-subset datapath.
// It supports R-type, ADDI, ADDIU, BEQ, J, LW, SW, LUI and ORI, and stalls on mem_ready.
// Optional build macro INSTR_COUNT_EN adds a 32-bit retired-instruction counter.
// Without the macro, instr_count is tied to zero.
module multi_cycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               Ext_op,
  output logic               illegal_op,
  output logic [31:0]        instr_count,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = STATE_W'(0),
    FETCH    = STATE_W'(1),
    DECODE   = STATE_W'(2),
    EXEC_R   = STATE_W'(3),
    WB_R     = STATE_W'(4),
    MEM_ADDR = STATE_W'(5),
    MEM_RD   = STATE_W'(6),
    WB_MEM   = STATE_W'(7),
    MEM_WR   = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    JUMP     = STATE_W'(10),
    EXEC_I   = STATE_W'(11),
    WB_I     = STATE_W'(12)
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;

  // Registered control outputs, loaded from the decode of the next state.
  logic        jump_pcw_q, jump_pcw_d;
  logic        pcwc_q, pcwc_d;
  logic        iord_q, iord_d;
  logic        memrd_q, memrd_d;
  logic        memwr_q, memwr_d;
  logic        regdst_q, regdst_d;
  logic        memtoreg_q, memtoreg_d;
  logic        regwr_q, regwr_d;
  logic        srca_q, srca_d;
  logic [1:0]  srcb_q, srcb_d;
  logic [2:0]  aluop_q, aluop_d;
  logic [1:0]  pcsrc_q, pcsrc_d;
  logic        ext_q, ext_d;
  logic        retire_c;

  // zero drives the PC write enable in the datapath, not the controller.
  logic        unused_zero;
  assign unused_zero = zero;

  // Opcode legality check used by DECODE.
  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ADDIU,
      OP_ORI, OP_LUI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  endfunction

  // Next-state logic, opcode latch, and output decode of the next state.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    jump_pcw_d = 1'b0;
    pcwc_d     = 1'b0;
    iord_d     = 1'b0;
    memrd_d    = 1'b0;
    memwr_d    = 1'b0;
    regdst_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwr_d    = 1'b0;
    srca_d     = 1'b0;
    srcb_d     = 2'b00;
    aluop_d    = 3'b000;
    pcsrc_d    = 2'b00;
    ext_d      = 1'b0;

    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_RTYPE:                          state_d = EXEC_R;
          OP_LW, OP_SW:                      state_d = MEM_ADDR;
          OP_BEQ:                            state_d = BRANCH;
          OP_J:                              state_d = JUMP;
          OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI: state_d = EXEC_I;
          default:                           state_d = FETCH;
        endcase
      end
      EXEC_R:   state_d = WB_R;
      WB_R:     state_d = FETCH;
      MEM_ADDR: state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_d = WB_MEM;
      WB_MEM:   state_d = FETCH;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      EXEC_I:   state_d = WB_I;
      WB_I:     state_d = FETCH;
      default:  state_d = IDLE;
    endcase

    case (state_d)
      FETCH: begin
        memrd_d = 1'b1;
        srcb_d  = 2'b01;
      end
      DECODE: begin
        srcb_d = 2'b11;
        ext_d  = 1'b1;
      end
      EXEC_R: begin
        srca_d  = 1'b1;
        aluop_d = 3'b010;
      end
      WB_R: begin
        regwr_d  = 1'b1;
        regdst_d = 1'b1;
      end
      MEM_ADDR: begin
        srca_d = 1'b1;
        srcb_d = 2'b10;
        ext_d  = 1'b1;
      end
      MEM_RD: begin
        memrd_d = 1'b1;
        iord_d  = 1'b1;
      end
      WB_MEM: begin
        regwr_d    = 1'b1;
        memtoreg_d = 1'b1;
      end
      MEM_WR: begin
        memwr_d = 1'b1;
        iord_d  = 1'b1;
      end
      BRANCH: begin
        srca_d  = 1'b1;
        aluop_d = 3'b001;
        pcwc_d  = 1'b1;
        pcsrc_d = 2'b01;
      end
      JUMP: begin
        jump_pcw_d = 1'b1;
        pcsrc_d    = 2'b10;
      end
      EXEC_I: begin
        srca_d = 1'b1;
        srcb_d = 2'b10;
        case (op_d)
          OP_LUI:  aluop_d = 3'b011;
          OP_ORI:  aluop_d = 3'b100;
          default: ext_d   = 1'b1;
        endcase
      end
      WB_I:    regwr_d = 1'b1;
      default: ;
    endcase
  end

  // State, latched opcode and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 6'd0;
      jump_pcw_q <= 1'b0;
      pcwc_q     <= 1'b0;
      iord_q     <= 1'b0;
      memrd_q    <= 1'b0;
      memwr_q    <= 1'b0;
      regdst_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwr_q    <= 1'b0;
      srca_q     <= 1'b0;
      srcb_q     <= 2'b00;
      aluop_q    <= 3'b000;
      pcsrc_q    <= 2'b00;
      ext_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      jump_pcw_q <= jump_pcw_d;
      pcwc_q     <= pcwc_d;
      iord_q     <= iord_d;
      memrd_q    <= memrd_d;
      memwr_q    <= memwr_d;
      regdst_q   <= regdst_d;
      memtoreg_q <= memtoreg_d;
      regwr_q    <= regwr_d;
      srca_q     <= srca_d;
      srcb_q     <= srcb_d;
      aluop_q    <= aluop_d;
      pcsrc_q    <= pcsrc_d;
      ext_q      <= ext_d;
    end
  end

  // IR/PC load in FETCH completes only on the cycle memory delivers the word.
  assign IRWrite     = (state_q == FETCH) && mem_ready;
  assign PCWrite     = jump_pcw_q || IRWrite;
  assign illegal_op  = (state_q == DECODE) && !op_legal(opcode);
  assign PCWriteCond = pcwc_q;
  assign IorD        = iord_q;
  assign MemRead     = memrd_q;
  assign MemWrite    = memwr_q;
  assign RegDst      = regdst_q;
  assign MemtoReg    = memtoreg_q;
  assign RegWrite    = regwr_q;
  assign ALUSrcA     = srca_q;
  assign ALUSrcB     = srcb_q;
  assign ALUOp       = aluop_q;
  assign PCSource    = pcsrc_q;
  assign Ext_op      = ext_q;
  assign state_o     = state_q;

  // An instruction retires on its final state's exit.
  always_comb begin
    retire_c = 1'b0;
    case (state_q)
      WB_R, WB_MEM, WB_I, BRANCH, JUMP: retire_c = 1'b1;
      MEM_WR:                           retire_c = mem_ready;
      default:                          retire_c = 1'b0;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] cnt_q;

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= 32'd0;
    else if (retire_c) cnt_q <= cnt_q + 32'd1;
  end

  assign instr_count = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire_c;
  assign instr_count   = 32'h0;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: a bench model pushes the expected
// state/controls/count each cycle and the sampled DUT outputs are popped against it.
module tb_multi_cycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        RegDst, MemtoReg, RegWrite, ALUSrcA, Ext_op, illegal_op;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [31:0] instr_count;
  logic [3:0]  state_o;

  multi_cycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Ext_op(Ext_op), .illegal_op(illegal_op),
    .instr_count(instr_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          ir_pulses;
  logic [3:0]  m_state;
  logic [5:0]  m_lop;
  logic [31:0] m_cnt;
  logic [18:0] obs_ctrl;

  assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
                     MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Ext_op,
                     illegal_op};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b001001,
                      6'b001101, 6'b001111, 6'b100011, 6'b101011};
  endfunction

  // Expected control word from the state table.
  function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic [5:0] lop,
                                           input logic [5:0] op, input logic rdy);
    logic pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, ext, ill;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, ext, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      4'd1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      4'd2:  begin asb = 2'b11; ext = 1; ill = !legal(op); end
      4'd3:  begin asa = 1; aop = 3'b010; end
      4'd4:  begin rw = 1; rd = 1; end
      4'd5:  begin asa = 1; asb = 2'b10; ext = 1; end
      4'd6:  begin mr = 1; iord = 1; end
      4'd7:  begin rw = 1; m2r = 1; end
      4'd8:  begin mw = 1; iord = 1; end
      4'd9:  begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
      4'd10: begin pcw = 1; pcs = 2'b10; end
      4'd11: begin
        asa = 1; asb = 2'b10;
        if (lop == 6'b001111)      aop = 3'b011;
        else if (lop == 6'b001101) aop = 3'b100;
        else                       ext = 1;
      end
      4'd12: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, ext, ill};
  endfunction

  function automatic logic [3:0] next_st(input logic [3:0] st, input logic [5:0] op,
                                         input logic [5:0] lop, input logic rdy);
    case (st)
      4'd0: return 4'd1;
      4'd1: return rdy ? 4'd2 : 4'd1;
      4'd2: begin
        if (op == 6'b000000) return 4'd3;
        if (op == 6'b100011 || op == 6'b101011) return 4'd5;
        if (op == 6'b000100) return 4'd9;
        if (op == 6'b000010) return 4'd10;
        if (op inside {6'b001000, 6'b001001, 6'b001111, 6'b001101}) return 4'd11;
        return 4'd1;
      end
      4'd3: return 4'd4;
      4'd5: return (lop == 6'b100011) ? 4'd6 : 4'd8;
      4'd6: return rdy ? 4'd7 : 4'd6;
      4'd8: return rdy ? 4'd1 : 4'd8;
      4'd11: return 4'd12;
      4'd4, 4'd7, 4'd9, 4'd10, 4'd12: return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  // One clock: drive inputs, push expectation, sample, pop and compare, advance model.
  task automatic step(input logic rdy, input logic [5:0] op);
    exp_t e, got;
    logic ret;
    mem_ready = rdy;
    opcode    = op;
    zero      = 1'($urandom);
    e.st   = m_state;
    e.ctrl = exp_ctrl(m_state, m_lop, op, rdy);
`ifdef INSTR_COUNT_EN
    e.cnt  = m_cnt;
`else
    e.cnt  = 32'h0;
`endif
    sb_q.push_back(e);
    #2;
    got = sb_q.pop_front();
    check_eq($sformatf("state@%0t", $time), 64'(state_o), 64'(got.st));
    check_eq($sformatf("ctrl_s%0d@%0t", got.st, $time), 64'(obs_ctrl), 64'(got.ctrl));
    check_eq($sformatf("count@%0t", $time), 64'(instr_count), 64'(got.cnt));
    if (IRWrite) ir_pulses++;
    ret = (m_state inside {4'd4, 4'd7, 4'd9, 4'd10, 4'd12}) || (m_state == 4'd8 && rdy);
    @(posedge clk);
    if (m_state == 4'd2) m_lop = op;
    if (ret) m_cnt = m_cnt + 32'd1;
    m_state = next_st(m_state, op, m_lop, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_state", 64'(state_o), 64'd0);
    check_eq("rst_ctrl", 64'(obs_ctrl), 64'd0);
    check_eq("rst_count", 64'(instr_count), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_state = 4'd0;
    m_lop   = 6'd0;
    m_cnt   = 32'd0;
  endtask

  // Run one instruction from FETCH back to FETCH with the given stall budgets.
  task automatic run_instr(input string tag, input logic [5:0] op, input int fstall,
                           input int mstall, input int exp_cycles, input bit abort_exec);
    int cyc = 0;
    int fs  = fstall;
    int ms  = mstall;
    bit left = 0;
    logic rdy;
    if (m_state == 4'd0) step(1'b1, op);
    ir_pulses = 0;
    while (cyc < 40) begin
      rdy = 1'b1;
      if (m_state == 4'd1 && fs > 0) begin rdy = 1'b0; fs--; end
      if ((m_state == 4'd6 || m_state == 4'd8) && ms > 0) begin rdy = 1'b0; ms--; end
      if (abort_exec && m_state == 4'd3) begin
        mem_ready = 1'b1;
        do_reset();
        return;
      end
      step(rdy, (m_state == 4'd1 || m_state == 4'd2) ? op : 6'($urandom));
      cyc++;
      if (m_state != 4'd1) left = 1;
      else if (left) break;
    end
    check_eq({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles));
    check_eq({tag, "_irwrite"}, 64'(ir_pulses), 64'(fstall >= 0 ? 1 : 0));
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    m_state = 4'd0; m_lop = 6'd0; m_cnt = 32'd0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    run_instr("rtype",   6'b000000, 0, 0, 4, 0);
    run_instr("rt_abort", 6'b000000, 0, 0, 0, 1);
    run_instr("addi",    6'b001000, 0, 0, 4, 0);
    run_instr("addiu",   6'b001001, 0, 0, 4, 0);
    run_instr("lui",     6'b001111, 0, 0, 4, 0);
    run_instr("ori",     6'b001101, 1, 0, 5, 0);
    run_instr("sw",      6'b101011, 0, 0, 4, 0);
    run_instr("sw_stall", 6'b101011, 0, 2, 6, 0);
    run_instr("lw",      6'b100011, 0, 0, 5, 0);
    run_instr("lw_stall", 6'b100011, 2, 3, 10, 0);
    run_instr("beq",     6'b000100, 0, 0, 3, 0);
    run_instr("j",       6'b000010, 0, 0, 3, 0);
    run_instr("illegal", 6'b111111, 0, 0, 2, 0);
    run_instr("illegal2", 6'b000001, 0, 0, 2, 0);

    do_reset();
    run_instr("c_sw",   6'b101011, 0, 0, 4, 0);
    run_instr("c_addi", 6'b001000, 0, 0, 4, 0);
    run_instr("c_j",    6'b000010, 0, 0, 3, 0);
`ifdef INSTR_COUNT_EN
    check_eq("count_three", 64'(instr_count), 64'd3);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    run_instr("wrap_j", 6'b000010, 0, 0, 3, 0);
    check_eq("count_wrap", 64'(instr_count), 64'd0);
`else
    check_eq("count_tied", 64'(instr_count), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout state=%0d", state_o);
    $fatal(1, "timeout");
  end

endmodule
